fetch_unit: RTL

Parameterised instruction-fetch and PC unit for the multi-cycle MiniSRC datapath. It generalises the fixed PC, PC-increment mux and PC adder path to configurable width, increment and offset size. It adds a variable-latency instruction-memory handshake, PC-relative and absolute redirect, and a fetch timeout fault. It sits between the control unit, instruction memory and the IR consumer (register-file address decode).

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_pc_adder.sv | 38 +++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit.
// State encoding, redirect selects and default PC stepping.
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic REDIR_ABS = 1'b0;
  localparam logic REDIR_REL = 1'b1;

  localparam int DEF_INC        = 4;
  localparam int DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read handshake.
// master = fetch side, slave = memory side.
interface fetch_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] oImemAddr;
  logic              oImemRead;
  logic [DATA_W-1:0] iImemData;
  logic              iImemValid;

  modport master (
    output oImemAddr,
    output oImemRead,
    input  iImemData,
    input  iImemValid
  );

  modport slave (
    input  oImemAddr,
    input  oImemRead,
    output iImemData,
    output iImemValid
  );

endinterface

// File: rtl/fetch_pc_adder.sv
// Next-PC arithmetic: sequential step and redirect target.
// Both results have the low alignment bits cleared.
module fetch_pc_adder
  import fetch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OFF_W      = 19,
  parameter int INC        = DEF_INC,
  parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] target,
  input  logic [OFF_W-1:0]  offset,
  input  logic              redir_sel,
  output logic [DATA_W-1:0] seq_pc,
  output logic [DATA_W-1:0] redir_pc
);

  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] MASK =
    ~((ONE << ALIGN_BITS) - ONE);

  logic [DATA_W-1:0] off_sx;
  logic [DATA_W-1:0] rel_pc;

  // Sign-extend the offset, form both candidates, align
  always_comb begin
    off_sx = {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
    rel_pc = pc + off_sx;
    seq_pc = (pc + DATA_W'(INC)) & MASK;
    if (redir_sel == REDIR_REL) begin
      redir_pc = rel_pc & MASK;
    end else begin
      redir_pc = target & MASK;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC unit with variable-latency memory
// handshake, absolute/relative redirect and sticky timeout.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OFF_W      = 19,
  parameter int INC        = DEF_INC,
  parameter int ALIGN_BITS = DEF_ALIGN_BITS,
  parameter int RESET_PC   = 0,
  parameter int WAIT_W     = 4
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iStart,
  input  logic              iRedirect,
  input  logic              iRedirSel,
  input  logic [DATA_W-1:0] iTarget,
  input  logic [OFF_W-1:0]  iOffset,
  fetch_if.master           imem,
  output logic [DATA_W-1:0] oInstr,
  output logic              oInstrValid,
  output logic [DATA_W-1:0] oInstrAddr,
  output logic [DATA_W-1:0] oPc,
  output logic              oBusy,
  output logic              oFault
);

  localparam logic [WAIT_W-1:0] CNT_LAST =
    WAIT_W'((1 << WAIT_W) - 2);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] iaddr_q, iaddr_d;
  logic              ivld_q, ivld_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] seq_pc;
  logic [DATA_W-1:0] redir_pc;

  fetch_pc_adder #(
    .DATA_W     (DATA_W),
    .OFF_W      (OFF_W),
    .INC        (INC),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_adder (
    .pc        (pc_q),
    .target    (iTarget),
    .offset    (iOffset),
    .redir_sel (iRedirSel),
    .seq_pc    (seq_pc),
    .redir_pc  (redir_pc)
  );

  // Next-state: redirect beats start in IDLE; data beats timeout in WAIT
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    fault_d = fault_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    ivld_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (iRedirect) begin
          pc_d = redir_pc;
        end else if (iStart && !fault_q) begin
          addr_d  = pc_q;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem.iImemValid) begin
          instr_d = imem.iImemData;
          iaddr_d = addr_q;
          pc_d    = seq_pc;
          ivld_d  = 1'b1;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any read at once
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      pc_q    <= DATA_W'(RESET_PC);
      addr_q  <= DATA_W'(RESET_PC);
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= '0;
      iaddr_q <= '0;
      ivld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      ivld_q  <= ivld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.oImemAddr = addr_q;
  assign imem.oImemRead = rd_q;
  assign oInstr         = instr_q;
  assign oInstrValid    = ivld_q;
  assign oInstrAddr     = iaddr_q;
  assign oPc            = pc_q;
  assign oBusy          = busy_q;
  assign oFault         = fault_q;

endmodule
